booth_mul_arbiter: RTL and testbench
====================================

Name: booth_mul_arbiter

Overview:
- Shares one sequential 4x4 signed Booth multiplier among NREQ requesters.
- Each requester sees a valid/ready request channel. All requesters share one response channel that is tagged with the requester ID.
- Round-robin arbitration. The block drives the multiplier's start/A/B inputs and collects its valid/Y outputs.
- A watchdog converts a lost multiplier completion into an error response.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, requester ID width, equals ceil(log2(NREQ)).
- TIMEOUT, 8, maximum cycles spent in BUSY before an error response (1..255).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester request valid.
- req_a  in  4*NREQ  signed multiplicand; requester i uses bits [4i+3:4i].
- req_b  in  4*NREQ  signed multiplier, same packing as req_a.
- req_ready  out  NREQ  one-hot grant/accept.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  IDW  ID of the requester being answered.
- rsp_y  out  8  signed product.
- rsp_err  out  1  watchdog fired; rsp_y is 0.
- busy  out  1  high in any state other than IDLE.
- mul_start  out  1  start pulse to the multiplier.
- mul_a  out  4  multiplier A operand.
- mul_b  out  4  multiplier B operand.
- mul_valid  in  1  multiplier done pulse, one cycle wide.
- mul_y  in  8  multiplier product.

Behaviour:
- Reset:
  - All outputs go to 0.
  - State goes to IDLE, the RR pointer to 0, and the watchdog counter to 0.
  - Reset asserted mid-operation aborts immediately. No response is issued for the aborted operation.
- States: IDLE, ISSUE, BUSY, RESP.
- IDLE:
  - req_ready is a combinational one-hot of the winning req_valid bit.
  - The search starts at index ptr and wraps modulo NREQ. req_ready is all-zero if no request is pending.
  - On accept (req_valid & req_ready), register the winner's A, B and ID. Set ptr = (winner+1) mod NREQ. Go to ISSUE.
- ISSUE, one cycle:
  - mul_start=1. mul_a and mul_b show the registered operands.
  - Go to BUSY and clear the watchdog.
- BUSY:
  - mul_start=0.
  - mul_a and mul_b stay stable through ISSUE, BUSY and RESP, because the multiplier samples A bits during its whole run.
  - On mul_valid: capture mul_y into rsp_y, set rsp_err=0, go to RESP.
  - Otherwise increment the watchdog. When the watchdog reaches TIMEOUT-1 without mul_valid: rsp_y=0, rsp_err=1, go to RESP.
- RESP:
  - rsp_valid=1. rsp_id, rsp_y and rsp_err stay stable until rsp_valid & rsp_ready.
  - On handshake, clear rsp_valid next cycle and return to IDLE.
  - The next grant occurs no earlier than the cycle after the handshake.
  - rsp_ready may be high before rsp_valid; a zero-wait handshake gives RESP a duration of one cycle.
- req_ready is 0 in every state except IDLE.
- mul_valid outside BUSY is ignored.
- Latency with a conforming multiplier (valid 5 cycles after the start cycle):
  - accept at cycle 0, mul_start at cycle 1, mul_valid at cycle 6, rsp_valid at cycle 7.
  - Throughput is one operation per 8 cycles with rsp_ready held high.
- Products pass through unmodified. The arbiter performs no arithmetic on mul_y.
- A requester dropping req_valid before it is granted is legal. The arbiter never grants a bit whose req_valid is low.

Test Plan:
- Single request: requester 2 sends A=3, B=-2 at cycle 0. Required: req_ready=4'b0100 in cycle 0, mul_start at cycle 1 with mul_a=4'h3 and mul_b=4'hE, rsp_valid at cycle 7 with rsp_id=2 and rsp_y=8'hFA (-6), rsp_err=0.
- Full contention: all four req_valid held high with rsp_ready=1. Required grants in order 0,1,2,3,0, spaced 8 cycles apart; each rsp_id matches its grant.
- RR fairness: after requester 1 is granted, assert only requesters 0 and 3. Required: 3 is granted next, then 0.
- Backpressure: rsp_ready=0 for 10 cycles after rsp_valid. Required: rsp_id, rsp_y and rsp_err stay stable; req_ready stays 0; mul_start never asserts. Release rsp_ready, then the next grant occurs one cycle after the handshake.
- Watchdog: stub the multiplier so mul_valid never arrives, TIMEOUT=8, A=2, B=3. Required: rsp_valid at cycle 10 with rsp_err=1 and rsp_y=0. A late mul_valid at cycle 12 is ignored.
- Reset mid-op: assert rst low at cycle 4 of an operation. Required: all outputs go to 0 asynchronously and ptr goes to 0. After release, a pending request from requester 3 alone is granted, and no stale response appears.

Source files
------------

// File: rtl/booth_mul_arbiter.sv
// Round-robin arbiter sharing one sequential 4x4 signed Booth multiplier among NREQ requesters.
// Responses are tagged with the requester ID; a watchdog turns a lost completion into an error.
module booth_mul_arbiter #(
   parameter int unsigned NREQ    = 4,
   parameter int unsigned IDW     = 2,
   parameter int unsigned TIMEOUT = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req_valid,
   input  logic [4*NREQ-1:0] req_a,
   input  logic [4*NREQ-1:0] req_b,
   output logic [NREQ-1:0]   req_ready,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [IDW-1:0]    rsp_id,
   output logic [7:0]        rsp_y,
   output logic              rsp_err,
   output logic              busy,
   output logic              mul_start,
   output logic [3:0]        mul_a,
   output logic [3:0]        mul_b,
   input  logic              mul_valid,
   input  logic [7:0]        mul_y
);

   typedef enum logic [1:0] {StIdle, StIssue, StBusy, StResp} state_e;

   state_e          state_q, state_d;
   logic [IDW-1:0]  ptr_q, ptr_d;
   logic [IDW-1:0]  id_q, id_d;
   logic [3:0]      a_q, a_d, b_q, b_d;
   logic [7:0]      wd_q, wd_d;
   logic [7:0]      y_q, y_d;
   logic            err_q, err_d;

   logic [NREQ-1:0] grant;
   logic [IDW-1:0]  win;
   logic            found;

   // First pending request at or after ptr, wrapping modulo NREQ.
   always_comb begin : rr_search
      logic [IDW-1:0] idx;
      idx   = '0;
      grant = '0;
      win   = '0;
      found = 1'b0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         idx = IDW'((32'(ptr_q) + k) % NREQ);
         if (!found && req_valid[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
      if (found) begin
         grant[win] = 1'b1;
      end
   end

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      id_d      = id_q;
      a_d       = a_q;
      b_d       = b_q;
      wd_d      = wd_q;
      y_d       = y_q;
      err_d     = err_q;
      req_ready = '0;
      mul_start = 1'b0;
      rsp_valid = 1'b0;
      unique case (state_q)
         StIdle: begin
            // Grant stays low while reset is held so every output reads zero.
            if (rst) begin
               req_ready = grant;
            end
            if (found && rst) begin
               id_d    = win;
               a_d     = req_a[32'(win)*4 +: 4];
               b_d     = req_b[32'(win)*4 +: 4];
               ptr_d   = IDW'((32'(win) + 1) % NREQ);
               state_d = StIssue;
            end
         end
         StIssue: begin
            mul_start = 1'b1;
            wd_d      = '0;
            state_d   = StBusy;
         end
         StBusy: begin
            if (mul_valid) begin
               y_d     = mul_y;
               err_d   = 1'b0;
               state_d = StResp;
            end else if (wd_q == 8'(TIMEOUT - 1)) begin
               y_d     = '0;
               err_d   = 1'b1;
               state_d = StResp;
            end else begin
               wd_d = wd_q + 8'd1;
            end
         end
         StResp: begin
            rsp_valid = 1'b1;
            if (rsp_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StIdle;
         ptr_q   <= '0;
         id_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         wd_q    <= '0;
         y_q     <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         id_q    <= id_d;
         a_q     <= a_d;
         b_q     <= b_d;
         wd_q    <= wd_d;
         y_q     <= y_d;
         err_q   <= err_d;
      end
   end

   assign busy    = (state_q != StIdle);
   assign mul_a   = a_q;
   assign mul_b   = b_q;
   assign rsp_id  = id_q;
   assign rsp_y   = y_q;
   assign rsp_err = err_q;

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Scoreboard bench for booth_mul_arbiter: a reference arbiter model pushes expected responses,
// a monitor pops them as the DUT answers; a behavioural multiplier stub closes the loop.
module tb_booth_mul_arbiter;

   localparam int NREQ    = 4;
   localparam int IDW     = 2;
   localparam int TIMEOUT = 8;
   localparam int LAT_OK  = 7;
   localparam int LAT_ERR = TIMEOUT + 2;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic [NREQ-1:0]   req_valid = '0;
   logic [4*NREQ-1:0] req_a = '0;
   logic [4*NREQ-1:0] req_b = '0;
   logic [NREQ-1:0]   req_ready;
   logic              rsp_valid;
   logic              rsp_ready = 1'b0;
   logic [IDW-1:0]    rsp_id;
   logic [7:0]        rsp_y;
   logic              rsp_err;
   logic              busy;
   logic              mul_start;
   logic [3:0]        mul_a;
   logic [3:0]        mul_b;
   logic              mul_valid = 1'b0;
   logic [7:0]        mul_y = '0;

   booth_mul_arbiter #(.NREQ(NREQ), .IDW(IDW), .TIMEOUT(TIMEOUT)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_y     (rsp_y),
      .rsp_err   (rsp_err),
      .busy      (busy),
      .mul_start (mul_start),
      .mul_a     (mul_a),
      .mul_b     (mul_b),
      .mul_valid (mul_valid),
      .mul_y     (mul_y)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [IDW-1:0] id;
      logic [7:0]     y;
      logic           err;
      int             gcyc;
      int             lat;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   int   mptr = 0;
   bit   busy_m = 1'b0;
   int   g_cyc = 0;
   logic [3:0] cur_a, cur_b;
   int   mul_mode = 0;  // 0: multiplier answers after 5 cycles, 1: answer lost
   bit   due_valid = 1'b0, late_valid = 1'b0;
   int   due_cyc = 0, late_cyc = 0;
   logic [7:0] due_y;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [7:0] prod(input logic [3:0] a, input logic [3:0] b);
      int av, bv;
      av = a[3] ? int'(a) - 16 : int'(a);
      bv = b[3] ? int'(b) - 16 : int'(b);
      return 8'(av * bv);
   endfunction

   task automatic new_ops(input int i);
      req_a[4*i +: 4] = 4'($urandom);
      req_b[4*i +: 4] = 4'($urandom);
   endtask

   // Reference arbiter: who must be granted now, and what the answer must be.
   task automatic check_grant(output int w);
      logic [NREQ-1:0] exp_rdy;
      exp_t e;
      w = -1;
      exp_rdy = '0;
      if (busy_m) begin
         chk("busy_active", busy, 1);
         chk("mul_a_stable", mul_a, cur_a);
         chk("mul_b_stable", mul_b, cur_b);
         chk("mul_start", mul_start, cyc == g_cyc + 1);
      end else begin
         chk("busy_idle", busy, 0);
         for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = (mptr + k) % NREQ;
            if (w < 0 && req_valid[idx]) w = idx;
         end
      end
      if (w >= 0) exp_rdy[w] = 1'b1;
      chk("req_ready", req_ready, exp_rdy);
      if (busy_m && rsp_valid && rsp_ready) busy_m = 1'b0;
      if (w >= 0) begin
         cur_a  = req_a[4*w +: 4];
         cur_b  = req_b[4*w +: 4];
         e.id   = IDW'(w);
         e.err  = (mul_mode != 0);
         e.y    = e.err ? 8'h00 : prod(cur_a, cur_b);
         e.gcyc = cyc;
         e.lat  = e.err ? LAT_ERR : LAT_OK;
         exp_q.push_back(e);
         mptr   = (w + 1) % NREQ;
         busy_m = 1'b1;
         g_cyc  = cyc;
      end
   endtask

   task automatic step(output int w);
      @(negedge clk);
      check_grant(w);
      @(posedge clk);
      #1;
   endtask

   task automatic check_zero_outputs(input string tag);
      chk({tag, "_req_ready"}, req_ready, 0);
      chk({tag, "_rsp_valid"}, rsp_valid, 0);
      chk({tag, "_rsp_id"}, rsp_id, 0);
      chk({tag, "_rsp_y"}, rsp_y, 0);
      chk({tag, "_rsp_err"}, rsp_err, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_mul_start"}, mul_start, 0);
      chk({tag, "_mul_a"}, mul_a, 0);
      chk({tag, "_mul_b"}, mul_b, 0);
   endtask

   // Multiplier stub: answers 5 cycles after the start cycle, or never (with a late stray pulse).
   initial forever begin
      @(posedge clk);
      #1;
      mul_valid = 1'b0;
      mul_y     = '0;
      if (due_valid && cyc == due_cyc) begin
         mul_valid = 1'b1;
         mul_y     = due_y;
         due_valid = 1'b0;
      end
      if (late_valid && cyc == late_cyc) begin
         mul_valid  = 1'b1;
         mul_y      = 8'h5A;
         late_valid = 1'b0;
      end
      @(negedge clk);
      if (rst && mul_start) begin
         if (mul_mode == 0) begin
            due_valid = 1'b1;
            due_cyc   = cyc + 5;
            due_y     = prod(mul_a, mul_b);
         end else begin
            late_valid = 1'b1;
            late_cyc   = cyc + 11;
         end
      end
   end

   // Response monitor.
   initial begin : monitor
      exp_t cur;
      bit   holding;
      holding = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            holding = 1'b0;
         end else begin
            if (holding && !rsp_valid) begin
               chk("rsp_valid_held", rsp_valid, 1);
               holding = 1'b0;
            end
            if (rsp_valid) begin
               if (!holding) begin
                  if (exp_q.size() == 0) begin
                     chk("rsp_unexpected", rsp_valid, 0);
                  end else begin
                     cur = exp_q.pop_front();
                     holding = 1'b1;
                     chk("rsp_latency", cyc - cur.gcyc, cur.lat);
                  end
               end
               if (holding) begin
                  chk("rsp_id", rsp_id, cur.id);
                  chk("rsp_y", rsp_y, cur.y);
                  chk("rsp_err", rsp_err, cur.err);
                  chk("mul_start_in_resp", mul_start, 0);
               end
               if (rsp_ready) holding = 1'b0;
            end
         end
      end
   end

   initial begin : stim
      int w, n;
      repeat (3) @(posedge clk);
      #1;
      check_zero_outputs("reset");
      rst = 1'b1;

      // Single request: requester 2, A=3, B=-2.
      rsp_ready = 1'b1;
      req_a[11:8] = 4'h3;
      req_b[11:8] = 4'hE;
      req_valid = 4'b0100;
      step(w);
      req_valid = '0;
      repeat (10) step(w);

      // Full contention.
      req_valid = '1;
      repeat (40) begin
         step(w);
         if (w >= 0) new_ops(w);
      end
      req_valid = '0;
      repeat (10) step(w);

      // Fairness: grant 1, then only 0 and 3 pending.
      req_valid = 4'b0010;
      n = 0;
      w = -1;
      while (w != 1 && n < 40) begin
         step(w);
         n++;
      end
      chk("fair_grant1_seen", w, 1);
      req_valid = 4'b1001;
      repeat (20) begin
         step(w);
         if (w >= 0) req_valid[w] = 1'b0;
      end

      // Backpressure.
      rsp_ready = 1'b0;
      req_valid = 4'b0001;
      new_ops(0);
      n = 0;
      while (!rsp_valid && n < 30) begin
         step(w);
         if (w >= 0) new_ops(w);
         n++;
      end
      chk("bp_rsp_seen", rsp_valid, 1);
      repeat (10) step(w);
      rsp_ready = 1'b1;
      repeat (12) begin
         step(w);
         if (w >= 0) new_ops(w);
      end
      req_valid = '0;
      repeat (10) step(w);

      // Watchdog, then a stray late mul_valid while the next op is issuing.
      mul_mode = 1;
      req_a[11:8] = 4'h2;
      req_b[11:8] = 4'h3;
      req_valid = 4'b0100;
      step(w);
      chk("wd_grant", w, 2);
      req_valid = 4'b0010;
      new_ops(1);
      repeat (5) step(w);
      mul_mode = 0;
      repeat (25) begin
         step(w);
         if (w >= 0) req_valid[w] = 1'b0;
      end

      // Randomized traffic.
      for (int t = 0; t < 400; t++) begin
         step(w);
         for (int i = 0; i < NREQ; i++) begin
            if (w == i) begin
               req_valid[i] = 1'($urandom_range(1, 0));
               new_ops(i);
            end else if (!req_valid[i]) begin
               if ($urandom_range(3, 0) == 0) begin
                  req_valid[i] = 1'b1;
                  new_ops(i);
               end
            end else if ($urandom_range(15, 0) == 0) begin
               req_valid[i] = 1'b0;
            end
         end
         rsp_ready = ($urandom_range(2, 0) != 0);
         if (!busy_m && $urandom_range(9, 0) == 0) mul_mode = ($urandom_range(4, 0) == 0) ? 1 : 0;
      end
      mul_mode  = 0;
      rsp_ready = 1'b1;
      req_valid = '0;
      repeat (20) step(w);

      // Reset mid-operation.
      req_valid = 4'b0001;
      new_ops(0);
      step(w);
      req_valid = 4'b1000;
      new_ops(3);
      repeat (3) step(w);
      #2;
      rst = 1'b0;
      due_valid  = 1'b0;
      late_valid = 1'b0;
      exp_q.delete();
      busy_m = 1'b0;
      mptr   = 0;
      #1;
      check_zero_outputs("midop_reset");
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      step(w);
      chk("post_reset_grant", w, 3);
      req_valid = '0;
      repeat (20) step(w);

      chk("drain_queue", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
